fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch over a variable-latency
//  req/ack instruction-memory port. Presents one fetched instruction at a time to the
//  IF/ID boundary with PC and PC+4. Supports decode stall, jump/branch redirect
//  (including kill of an in-flight fetch) and a sticky fetch-timeout flag.
//  Sits between the imem interface and the IF/ID pipeline register.
// PARAMETERS
//  RESET_PC  32'd64  PC of the first fetch after reset
//  MAX_WAIT  16      cycles an outstanding request may wait before fetch_err sets
//  CNT_W     8       width of the wait counter; must hold MAX_WAIT
// PORTS
//  clk            in   1   clock; all state changes on the rising edge
//  reset          in   1   synchronous, active-high reset
//  stall          in   1   decode cannot accept the instruction slot this cycle
//  redirect_valid in   1   one-cycle pulse: jump or branch taken
//  redirect_pc    in   32  redirect target, sampled when redirect_valid=1
//  imem_req       out  1   fetch request; held high until imem_ack
//  imem_addr      out  32  fetch address; stable while imem_req=1
//  imem_ack       in   1   one-cycle pulse: imem_rdata valid for the current request
//  imem_rdata     in   32  instruction word
//  if_valid       out  1   instruction slot holds a valid instruction
//  if_pc          out  32  PC of the slot instruction
//  if_pc4         out  32  if_pc + 4
//  if_instr       out  32  slot instruction word
//  fetch_err      out  1   sticky: an outstanding request exceeded MAX_WAIT cycles
// BEHAVIOUR
//  Reset (reset=1 at an edge):
//   state=IDLE; pc=RESET_PC; req_addr=RESET_PC; imem_req=0; if_valid=0;
//   if_pc=RESET_PC; if_pc4=RESET_PC+4; if_instr=0; fetch_err=0; wait_cnt=0.
//   Reset mid-request abandons the request. Any late imem_ack is ignored while in IDLE.
//  Registers:
//   pc is the next address to fetch. req_addr is the address of the outstanding request.
//   imem_addr=req_addr. imem_req=1 exactly in FETCH and DRAIN (registered).
//  Slot consumption: the slot is consumed at an edge when if_valid=1 and stall=0.
//   A consumed slot clears if_valid unless it is refilled at the same edge.
//  States:
//   IDLE  No request. If the slot is free (if_valid=0 or consumed this cycle):
//         req_addr<=pc and go to FETCH. Otherwise stay in IDLE.
//   FETCH Request outstanding.
//         - imem_ack and no redirect: if_valid<=1, if_instr<=imem_rdata,
//           if_pc<=req_addr, if_pc4<=req_addr+4, pc<=req_addr+4; go to IDLE.
//         - imem_ack with redirect: discard data; pc<=target; req_addr<=target; stay in FETCH.
//         - redirect without ack: pc<=target; go to DRAIN. req_addr is unchanged.
//  DRAIN Old request still outstanding; its response is discarded.
//         - imem_ack: req_addr<=pc; go to FETCH.
//         - a further redirect updates pc only.
//  Redirect:
//   - Valid in any state. Clears if_valid at the same edge.
//   - Takes priority over stall and over slot consumption.
//   - Target is word-aligned: {redirect_pc[31:2],2'b00}.
//   - Redirect in IDLE: pc<=target; next IDLE cycle issues the fetch (slot now free).
//  Throughput: at most 1 instruction per 2 cycles with 1-cycle imem latency.
//   The earliest ack is the cycle after imem_req rises. An ack while imem_req=0 is ignored.
//  Wait counter:
//   - wait_cnt clears on entry to FETCH/DRAIN.
//   - It increments each cycle with imem_req=1 and no ack, and saturates.
//   - When wait_cnt reaches MAX_WAIT, fetch_err<=1. fetch_err clears only on reset.
//   - The request stays asserted.
//  Arithmetic: all PC adds are 32-bit modulo. 32'hFFFFFFFC+4 wraps to 0 silently.
// TESTING
//  1. Reset release, ack 1 cycle after each req, stall=0:
//     imem_addr sequence 64,68,72; if_pc=64/if_pc4=68 then 68, 72.
//     if_valid high every 2nd cycle.
//  2. stall=1 with slot full:
//     imem_req stays 0; if_pc/if_instr hold.
//     stall drops -> next edge FETCH with imem_addr=next PC.
//  3. Redirect to 0x200 while a fetch of 0x48 is outstanding, ack 3 cycles later:
//     the 0x48 data is never in the slot.
//     imem_addr stays 0x48 until ack, then 0x200. if_pc=0x200.
//  4. Redirect and imem_ack in the same cycle:
//     data discarded; if_valid=0; next request address is the target.
//     Redirect to 0x203 is fetched at 0x200.
//  5. No ack for MAX_WAIT cycles:
//     fetch_err rises after exactly 16 waiting cycles and stays 1 after a later ack.
//     Cleared only by reset.
//  6. Assert reset mid-FETCH and ack during reset:
//     all outputs return to reset values. First fetch after release is at 64.

Source files
------------

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the program counter and sequences instruction fetch over a
// variable-latency req/ack instruction-memory port. One fetched instruction at
// a time is held in the IF/ID slot together with its PC and PC+4. Handles
// decode stall, jump/branch redirect (including killing an in-flight fetch)
// and raises a sticky error when a request waits too long for its ack.
//
// Ports
//   clk              in   1   clock, rising edge
//   i_reset          in   1   synchronous active-high reset
//   i_stall          in   1   decode cannot take the slot this cycle
//   i_redirect_valid in   1   one-cycle pulse: jump/branch taken
//   i_redirect_pc    in   32  redirect target (low two bits ignored)
//   o_imem_req       out  1   fetch request, held until i_imem_ack
//   o_imem_addr      out  32  fetch address, stable while o_imem_req=1
//   i_imem_ack       in   1   one-cycle pulse: i_imem_rdata valid
//   i_imem_rdata     in   32  instruction word
//   o_if_valid       out  1   slot holds a valid instruction
//   o_if_pc          out  32  PC of the slot instruction
//   o_if_pc4         out  32  o_if_pc + 4
//   o_if_instr       out  32  slot instruction word
//   o_fetch_err      out  1   sticky: a request waited MAX_WAIT cycles
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd64,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_pc4,
  output logic [31:0] o_if_instr,
  output logic        o_fetch_err
);

  typedef enum logic [1:0] {
    ST_IDLE,   // no request outstanding
    ST_FETCH,  // request outstanding, response will be used
    ST_DRAIN   // request outstanding, response will be discarded
  } state_t;

  state_t           r_state,    w_state_next;
  logic [31:0]      r_pc,       w_pc_next;
  logic [31:0]      r_req_addr, w_req_addr_next;
  logic             r_if_valid, w_if_valid_next;
  logic [31:0]      r_if_pc,    w_if_pc_next;
  logic [31:0]      r_if_pc4,   w_if_pc4_next;
  logic [31:0]      r_if_instr, w_if_instr_next;
  logic             r_fetch_err, w_fetch_err_next;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_next;

  logic [31:0] w_target;
  logic        w_consume;
  logic        w_restart;

  // Redirect targets are forced to word alignment.
  assign w_target  = i_redirect_pc & 32'hFFFF_FFFC;
  assign w_consume = r_if_valid && !i_stall;

  assign o_imem_req  = (r_state != ST_IDLE);
  assign o_imem_addr = r_req_addr;
  assign o_if_valid  = r_if_valid;
  assign o_if_pc     = r_if_pc;
  assign o_if_pc4    = r_if_pc4;
  assign o_if_instr  = r_if_instr;
  assign o_fetch_err = r_fetch_err;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_req_addr_next  = r_req_addr;
    w_if_valid_next  = r_if_valid && !w_consume;
    w_if_pc_next     = r_if_pc;
    w_if_pc4_next    = r_if_pc4;
    w_if_instr_next  = r_if_instr;
    w_fetch_err_next = r_fetch_err;
    w_wait_cnt_next  = r_wait_cnt;
    w_restart        = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // A redirect here only moves pc; the fetch goes out next cycle.
        if (i_redirect_valid) begin
          w_pc_next = w_target;
        end else if (!r_if_valid || w_consume) begin
          w_req_addr_next = r_pc;
          w_state_next    = ST_FETCH;
          w_restart       = 1'b1;
        end
      end
      ST_FETCH: begin
        if (i_redirect_valid) begin
          w_pc_next = w_target;
          if (i_imem_ack) begin
            // Old data dropped; the target request starts immediately.
            w_req_addr_next = w_target;
            w_restart       = 1'b1;
          end else begin
            w_state_next = ST_DRAIN;
            w_restart    = 1'b1;
          end
        end else if (i_imem_ack) begin
          w_if_valid_next = 1'b1;
          w_if_instr_next = i_imem_rdata;
          w_if_pc_next    = r_req_addr;
          w_if_pc4_next   = r_req_addr + 32'd4;
          w_pc_next       = r_req_addr + 32'd4;
          w_state_next    = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (i_redirect_valid) begin
          w_pc_next = w_target;
        end
        if (i_imem_ack) begin
          // A redirect landing with the ack wins over the older pc.
          w_req_addr_next = i_redirect_valid ? w_target : r_pc;
          w_state_next    = ST_FETCH;
          w_restart       = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Redirect overrides stall and consumption: the slot is always flushed.
    if (i_redirect_valid) begin
      w_if_valid_next = 1'b0;
    end

    if (w_restart) begin
      w_wait_cnt_next = '0;
    end else if (o_imem_req && !i_imem_ack && (r_wait_cnt != {CNT_W{1'b1}})) begin
      w_wait_cnt_next = r_wait_cnt + 1'b1;
    end

    if (w_wait_cnt_next >= CNT_W'(MAX_WAIT)) begin
      w_fetch_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_if_valid  <= 1'b0;
      r_if_pc     <= RESET_PC;
      r_if_pc4    <= RESET_PC + 32'd4;
      r_if_instr  <= '0;
      r_fetch_err <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_req_addr  <= w_req_addr_next;
      r_if_valid  <= w_if_valid_next;
      r_if_pc     <= w_if_pc_next;
      r_if_pc4    <= w_if_pc4_next;
      r_if_instr  <= w_if_instr_next;
      r_fetch_err <= w_fetch_err_next;
      r_wait_cnt  <= w_wait_cnt_next;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. Instruction memory is a pure
// function of address. The reference model is the architectural instruction
// stream: after reset or a redirect the next consumed instruction is at the
// start/target address, and each consumed instruction is followed by the one
// at PC+4. A monitor compares every consumed slot against that stream.
// Directed sequences cover reset, throughput, stall, redirect kill,
// redirect-with-ack, fetch timeout and reset mid-fetch.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'd64;
  localparam int          MAX_WAIT = 16;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_stall = 1'b0;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_pc4;
  logic [31:0] o_if_instr;
  logic        o_fetch_err;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC (RESET_PC),
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (8)
  ) dut (
    .clk              (clk),
    .i_reset          (i_reset),
    .i_stall          (i_stall),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_imem_req       (o_imem_req),
    .o_imem_addr      (o_imem_addr),
    .i_imem_ack       (i_imem_ack),
    .i_imem_rdata     (i_imem_rdata),
    .o_if_valid       (o_if_valid),
    .o_if_pc          (o_if_pc),
    .o_if_pc4         (o_if_pc4),
    .o_if_instr       (o_if_instr),
    .o_fetch_err      (o_fetch_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Expected next consumed PC(s) of the architectural stream.
  logic [31:0] exp_q [$];

  // Automatic imem responder controls.
  bit auto_ack = 1'b0;
  int lat_min  = 1;
  int lat_max  = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(RESET_PC);
  endtask

  task automatic model_redirect(input logic [31:0] t);
    exp_q.delete();
    exp_q.push_back({t[31:2], 2'b00});
  endtask

  // Two reset edges, then checks of all reset values, then release.
  task automatic apply_reset(input bit ack_during);
    i_reset          = 1'b1;
    i_stall          = 1'b0;
    i_redirect_valid = 1'b0;
    model_reset();
    if (ack_during) begin
      i_imem_ack   = 1'b1;
      i_imem_rdata = 32'hDEAD_BEEF;
    end
    tick();
    tick();
    if (ack_during) i_imem_ack = 1'b0;
    @(negedge clk);
    check("rst_req",    32'(o_imem_req),  32'd0);
    check("rst_addr",   o_imem_addr,      RESET_PC);
    check("rst_valid",  32'(o_if_valid),  32'd0);
    check("rst_pc",     o_if_pc,          RESET_PC);
    check("rst_pc4",    o_if_pc4,         RESET_PC + 32'd4);
    check("rst_instr",  o_if_instr,       32'd0);
    check("rst_err",    32'(o_fetch_err), 32'd0);
    tick();
    i_reset = 1'b0;
  endtask

  // Waits (bounded) for a request, then checks its address.
  task automatic wait_req(input string name, input logic [31:0] exp_addr);
    int n;
    n = 0;
    while (o_imem_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({name, "_req"},  32'(o_imem_req), 32'd1);
    check({name, "_addr"}, o_imem_addr,     exp_addr);
  endtask

  task automatic ack_now();
    i_imem_ack   = 1'b1;
    i_imem_rdata = mem_word(o_imem_addr);
    tick();
    i_imem_ack   = 1'b0;
  endtask

  // Scoreboard monitor: every consumed slot is checked against the stream.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (i_reset === 1'b0 && o_if_valid === 1'b1 && i_stall === 1'b0 &&
          i_redirect_valid === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL slot_unexpected: got pc %h, expected no instruction", o_if_pc);
        end else begin
          e = exp_q.pop_front();
          check("slot_pc",    o_if_pc,    e);
          check("slot_pc4",   o_if_pc4,   e + 32'd4);
          check("slot_instr", o_if_instr, mem_word(e));
          exp_q.push_back(e + 32'd4);
        end
      end
    end
  end

  // Automatic imem responder with latency lat_min..lat_max cycles.
  initial begin
    int  waited;
    int  lat;
    bit  fresh;
    fresh  = 1'b1;
    waited = 0;
    lat    = 1;
    forever begin
      tick();
      if (auto_ack) begin
        i_imem_ack = 1'b0;
        if (i_reset || !o_imem_req) begin
          fresh = 1'b1;
        end else begin
          if (fresh) begin
            fresh  = 1'b0;
            waited = 0;
            lat    = int'($urandom_range(lat_max, lat_min));
          end
          waited++;
          if (waited >= lat) begin
            i_imem_ack   = 1'b1;
            i_imem_rdata = mem_word(o_imem_addr);
            fresh        = 1'b1;
          end
        end
      end else begin
        fresh = 1'b1;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] t;

    // 1: reset release, ack in the first request cycle, no stall.
    apply_reset(1'b0);
    auto_ack = 1'b1;
    lat_min  = 1;
    lat_max  = 1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      if (k == 6) i_stall = 1'b1;
      @(negedge clk);
      check("t1_req",   32'(o_imem_req), 32'(k % 2));
      check("t1_valid", 32'(o_if_valid), 32'((k > 0) && (k % 2 == 0)));
      if (k % 2 == 1) check("t1_addr", o_imem_addr, RESET_PC + 32'((k - 1) * 2));
      if (k > 0 && k % 2 == 0) begin
        check("t1_pc",  o_if_pc,  RESET_PC + 32'((k - 2) * 2));
        check("t1_pc4", o_if_pc4, RESET_PC + 32'((k - 2) * 2) + 32'd4);
      end
    end

    // 2: stall with slot full holds everything; release fetches next PC.
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      check("t2_req",   32'(o_imem_req), 32'd0);
      check("t2_valid", 32'(o_if_valid), 32'd1);
      check("t2_pc",    o_if_pc,         32'd72);
      check("t2_instr", o_if_instr,      mem_word(32'd72));
    end
    tick();
    i_stall = 1'b0;
    @(negedge clk);
    check("t2_req_rel", 32'(o_imem_req), 32'd0);
    tick();
    @(negedge clk);
    check("t2_req_next",  32'(o_imem_req), 32'd1);
    check("t2_addr_next", o_imem_addr,     32'd76);
    check("t2_valid_nxt", 32'(o_if_valid), 32'd0);

    // 3: redirect to 0x200 while 0x48 is outstanding, ack three cycles later.
    auto_ack   = 1'b0;
    i_imem_ack = 1'b0;
    apply_reset(1'b0);
    wait_req("t3a", 32'd64);
    ack_now();
    wait_req("t3b", 32'd68);
    ack_now();
    wait_req("t3c", 32'h48);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h200;
    model_redirect(32'h200);
    tick();
    i_redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t3_drain_req",  32'(o_imem_req), 32'd1);
      check("t3_drain_addr", o_imem_addr,     32'h48);
      tick();
    end
    i_imem_ack   = 1'b1;
    i_imem_rdata = mem_word(32'h48);
    @(negedge clk);
    check("t3_ack_addr", o_imem_addr, 32'h48);
    tick();
    i_imem_ack = 1'b0;
    wait_req("t3d", 32'h200);
    ack_now();
    @(negedge clk);
    check("t3_valid", 32'(o_if_valid), 32'd1);
    check("t3_pc",    o_if_pc,         32'h200);
    check("t3_instr", o_if_instr,      mem_word(32'h200));

    // 4: redirect and ack in the same cycle; 0x203 is fetched at 0x200.
    wait_req("t4a", 32'h204);
    i_imem_ack       = 1'b1;
    i_imem_rdata     = mem_word(32'h204);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h203;
    model_redirect(32'h203);
    tick();
    i_imem_ack       = 1'b0;
    i_redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_req",   32'(o_imem_req), 32'd1);
    check("t4_addr",  o_imem_addr,     32'h200);
    check("t4_valid", 32'(o_if_valid), 32'd0);
    ack_now();
    @(negedge clk);
    check("t4_slot_valid", 32'(o_if_valid), 32'd1);
    check("t4_slot_pc",    o_if_pc,         32'h200);
    check("t4_slot_pc4",   o_if_pc4,        32'h204);

    // 5: no ack for MAX_WAIT cycles raises the sticky error.
    apply_reset(1'b0);
    wait_req("t5", RESET_PC);
    for (int k = 1; k <= MAX_WAIT + 1; k++) begin
      if (k > 1) tick();
      @(negedge clk);
      if (k == MAX_WAIT) check("t5_err_before", 32'(o_fetch_err), 32'd0);
      if (k == MAX_WAIT + 1) begin
        check("t5_err_after", 32'(o_fetch_err), 32'd1);
        check("t5_req_held",  32'(o_imem_req),  32'd1);
      end
    end
    ack_now();
    auto_ack = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("t5_err_sticky", 32'(o_fetch_err), 32'd1);

    // 6: reset mid-fetch with ack during reset; first fetch after is at 64.
    auto_ack   = 1'b0;
    i_imem_ack = 1'b0;
    apply_reset(1'b0);
    wait_req("t6a", RESET_PC);
    apply_reset(1'b1);
    @(negedge clk);
    check("t6_req_idle", 32'(o_imem_req), 32'd0);
    wait_req("t6b", RESET_PC);
    ack_now();
    @(negedge clk);
    check("t6_valid", 32'(o_if_valid), 32'd1);
    check("t6_pc",    o_if_pc,         RESET_PC);
    check("t6_instr", o_if_instr,      mem_word(RESET_PC));

    // Random phase: stalls, redirects (some near the top of memory to wrap).
    apply_reset(1'b0);
    auto_ack = 1'b1;
    lat_min  = 1;
    lat_max  = 4;
    for (int c = 0; c < 3000; c++) begin
      i_stall = ($urandom_range(3, 0) == 0);
      if ($urandom_range(15, 0) == 0) begin
        if ($urandom_range(3, 0) == 0) t = 32'hFFFF_FFE0 | 32'($urandom_range(31, 0));
        else                           t = 32'($urandom_range(4095, 0));
        i_redirect_valid = 1'b1;
        i_redirect_pc    = t;
        model_redirect(t);
      end else begin
        i_redirect_valid = 1'b0;
      end
      tick();
    end
    i_redirect_valid = 1'b0;
    i_stall          = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("rand_err", 32'(o_fetch_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
